// File: rtl/matmul_seq_nxn.sv
// Sequential NxN matrix multiplier C = A x B, one MAC per cycle, valid/ready in and out.
// Define MATMUL_SIGNED_EN for two's-complement operands and a signed result.
module matmul_seq_nxn #(
  parameter int N       = 2,
  parameter int W       = 2,
  parameter int MAX_VAL = 2,
  localparam int ACC_W  = 2*W + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  localparam int NN = N * N;
  localparam int CW = $clog2(NN);
  localparam int KW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);
  localparam logic [KW-1:0] LAST_K   = KW'(N - 1);

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

  state_t state, state_d;

  logic [W-1:0]     a_mem [NN];
  logic [W-1:0]     b_mem [NN];
  logic [ACC_W-1:0] c_mem [NN];

  logic [CW-1:0]    cnt, idx, a_idx, b_idx, c_idx;
  logic [KW-1:0]    i, j, k;
  logic [ACC_W-1:0] acc, a_ext, b_ext, mac;
  logic             started, in_fire, out_fire, last_mac;

  function automatic logic out_of_range(input logic [W-1:0] e);
`ifdef MATMUL_SIGNED_EN
    return (int'($signed(e)) > MAX_VAL) || (int'($signed(e)) < -MAX_VAL);
`else
    return int'(e) > MAX_VAL;
`endif
  endfunction

  // Operand fetch and MAC; the extension mode is the only difference between builds.
  always_comb begin
    a_idx = CW'(int'(i) * N + int'(k));
    b_idx = CW'(int'(k) * N + int'(j));
    c_idx = CW'(int'(i) * N + int'(j));
`ifdef MATMUL_SIGNED_EN
    a_ext = {{(ACC_W-W){a_mem[a_idx][W-1]}}, a_mem[a_idx]};
    b_ext = {{(ACC_W-W){b_mem[b_idx][W-1]}}, b_mem[b_idx]};
`else
    a_ext = {{(ACC_W-W){1'b0}}, a_mem[a_idx]};
    b_ext = {{(ACC_W-W){1'b0}}, b_mem[b_idx]};
`endif
    mac      = acc + a_ext * b_ext;
    last_mac = (i == LAST_K) && (j == LAST_K) && (k == LAST_K);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    in_fire   = 1'b0;
    out_fire  = 1'b0;
    busy      = (state == COMPUTE) || (state == DRAIN);
    out_last  = (state == DRAIN) && (idx == LAST_IDX);
    out_data  = (state == DRAIN && !err) ? c_mem[idx] : '0;
    if (ena) begin
      in_ready  = (state == LOAD) && started && !clr;
      out_valid = (state == DRAIN);
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
      if (clr) begin
        state_d = LOAD;
      end else begin
        case (state)
          LOAD:    if (in_fire && cnt == LAST_IDX) state_d = COMPUTE;
          COMPUTE: if (last_mac) state_d = DRAIN;
          DRAIN:   if (out_fire && idx == LAST_IDX) state_d = LOAD;
          default: state_d = LOAD;
        endcase
      end
    end
  end

  // in_ready stays low after reset until the first enabled edge has been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      cnt <= '0; idx <= '0;
      i <= '0; j <= '0; k <= '0;
      acc <= '0;
      err <= 1'b0;
    end else if (ena) begin
      started <= 1'b1;
      if (clr) begin
        cnt <= '0; idx <= '0;
        i <= '0; j <= '0; k <= '0;
        acc <= '0;
        err <= 1'b0;
      end else begin
        case (state)
          LOAD: if (in_fire) begin
            if (out_of_range(in_a) || out_of_range(in_b)) err <= 1'b1;
            if (cnt == LAST_IDX) begin
              cnt <= '0;
              i <= '0; j <= '0; k <= '0;
              acc <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          COMPUTE: begin
            if (k == LAST_K) begin
              acc <= '0;
              k   <= '0;
              if (j == LAST_K) begin
                j <= '0;
                i <= (i == LAST_K) ? '0 : i + 1'b1;
              end else begin
                j <= j + 1'b1;
              end
            end else begin
              acc <= mac;
              k   <= k + 1'b1;
            end
          end
          DRAIN: if (out_fire) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              cnt <= '0;
              err <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      a_mem[cnt] <= in_a;
      b_mem[cnt] <= in_b;
    end
    if (ena && !clr && state == COMPUTE && k == LAST_K) c_mem[c_idx] <= mac;
  end

endmodule

// File: tb/tb_matmul_seq_nxn.sv
// Bench for matmul_seq_nxn (N=2): directed table, hand-written corner cases and random jobs vs a model.
// Follows MATMUL_SIGNED_EN so the same file checks either build.
module tb_matmul_seq_nxn;

  localparam int N = 2;
`ifdef MATMUL_SIGNED_EN
  localparam int W = 3;
  localparam int MAX_VAL = 3;
`else
  localparam int W = 2;
  localparam int MAX_VAL = 2;
`endif
  localparam int ACC_W = 2*W + $clog2(N);
  localparam int LAT = N*N*N + 1;

  typedef struct packed {
    logic [3:0][W-1:0]     a;
    logic [3:0][W-1:0]     b;
    logic [3:0][ACC_W-1:0] c;
    logic                  e;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n, ena, clr, in_valid, in_ready, out_valid, out_ready, out_last, busy, err;
  logic [W-1:0]     in_a, in_b;
  logic [ACC_W-1:0] out_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs = 0;
  vec_t vecs [4];

  matmul_seq_nxn #(.N(N), .W(W), .MAX_VAL(MAX_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic vec_t mk_vec(input int a0, a1, a2, a3, b0, b1, b2, b3,
                                  c0, c1, c2, c3, input logic e);
    vec_t v;
    v.a[0] = W'(a0); v.a[1] = W'(a1); v.a[2] = W'(a2); v.a[3] = W'(a3);
    v.b[0] = W'(b0); v.b[1] = W'(b1); v.b[2] = W'(b2); v.b[3] = W'(b3);
    v.c[0] = ACC_W'(c0); v.c[1] = ACC_W'(c1); v.c[2] = ACC_W'(c2); v.c[3] = ACC_W'(c3);
    v.e = e;
    return v;
  endfunction

  function automatic int elem_val(input logic [W-1:0] x);
`ifdef MATMUL_SIGNED_EN
    return int'($signed(x));
`else
    return int'(x);
`endif
  endfunction

  function automatic logic [W-1:0] rand_elem(input bit wild);
    int v;
    if (wild) return W'($urandom_range(0, (1 << W) - 1));
`ifdef MATMUL_SIGNED_EN
    v = int'($urandom_range(0, 2*MAX_VAL)) - MAX_VAL;
`else
    v = int'($urandom_range(0, MAX_VAL));
`endif
    return W'(v);
  endfunction

  // Feeds all N*N operand beats, recording the cycle of the final handshake.
  task automatic applyStimulus(input logic [3:0][W-1:0] a, input logic [3:0][W-1:0] b);
    int waited;
    for (int e = 0; e < 4; e++) begin
      in_a = a[e];
      in_b = b[e];
      in_valid = 1'b1;
      waited = 0;
      while (!in_ready && waited < 50) begin
        step();
        waited++;
      end
      if (!in_ready) begin
        checkOutput("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      last_hs = cyc;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drainJob(input logic [3:0][ACC_W-1:0] exp, input logic exp_err,
                          input int bp_beat, input int exp_lat);
    int waited, b, hold;
    waited = 0; b = 0; hold = 0;
    out_ready = 1'b0;
    while (!out_valid && waited < 200) begin
      step();
      waited++;
    end
    if (!out_valid) begin
      checkOutput("first_valid_timeout", 0, 1);
      return;
    end
    checkOutput("latency", cyc - last_hs, exp_lat);
    while (b < 4 && waited < 200) begin
      if (out_valid) begin
        checkOutput("beat_data", int'(out_data), int'(exp[b]));
        checkOutput("beat_last", int'(out_last), (b == 3) ? 1 : 0);
        checkOutput("beat_err", int'(err), int'(exp_err));
        if (b == bp_beat && hold < 3) begin
          out_ready = 1'b0;
          hold++;
        end else begin
          out_ready = 1'b1;
          b++;
        end
      end else begin
        checkOutput("valid_drop", 0, 1);
        out_ready = 1'b0;
      end
      step();
      waited++;
    end
    out_ready = 1'b0;
    if (b < 4) checkOutput("drain_timeout", b, 4);
    checkOutput("err_cleared", int'(err), 0);
    checkOutput("valid_after_last", int'(out_valid), 0);
    checkOutput("busy_after_last", int'(busy), 0);
  endtask

  // Reference: plain matrix product on integer element values.
  task automatic randomJob(input int bp_beat);
    logic [3:0][W-1:0]     a, b;
    logic [3:0][ACC_W-1:0] c;
    logic e;
    int s;
    bit wild;
    wild = ($urandom_range(0, 3) == 0);
    e = 1'b0;
    for (int x = 0; x < 4; x++) begin
      a[x] = rand_elem(wild);
      b[x] = rand_elem(wild);
      if (elem_val(a[x]) > MAX_VAL || elem_val(a[x]) < -MAX_VAL) e = 1'b1;
      if (elem_val(b[x]) > MAX_VAL || elem_val(b[x]) < -MAX_VAL) e = 1'b1;
    end
    for (int r = 0; r < N; r++) begin
      for (int col = 0; col < N; col++) begin
        s = 0;
        for (int kk = 0; kk < N; kk++) s += elem_val(a[r*N+kk]) * elem_val(b[kk*N+col]);
        c[r*N+col] = e ? '0 : ACC_W'(s);
      end
    end
    applyStimulus(a, b);
    drainJob(c, e, bp_beat, LAT);
  endtask

  initial begin
    int seen;
`ifdef MATMUL_SIGNED_EN
    vecs[0] = mk_vec(-1, 2, 3, 0,   1, 0, 0, 1,   -1, 2, 3, 0,   1'b0);
    vecs[1] = mk_vec(-3, -3, -3, -3, -3, -3, -3, -3, 18, 18, 18, 18, 1'b0);
    vecs[2] = mk_vec(-4, 1, 1, 1,   1, 0, 0, 1,   0, 0, 0, 0,   1'b1);
    vecs[3] = mk_vec(1, 2, 3, -1,   2, -1, 0, 3,  2, 5, 6, -6,   1'b0);
`else
    vecs[0] = mk_vec(1, 2, 2, 1,    2, 0, 1, 2,   4, 4, 5, 2,    1'b0);
    vecs[1] = mk_vec(3, 1, 1, 1,    1, 0, 0, 1,   0, 0, 0, 0,    1'b1);
    vecs[2] = mk_vec(2, 2, 2, 2,    2, 2, 2, 2,   8, 8, 8, 8,    1'b0);
    vecs[3] = mk_vec(1, 0, 0, 1,    2, 1, 0, 2,   2, 1, 0, 2,    1'b0);
`endif
    rst_n = 1'b0; ena = 1'b1; clr = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #1;
    checkOutput("reset_in_ready", int'(in_ready), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_data", int'(out_data), 0);
    checkOutput("reset_out_last", int'(out_last), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_err", int'(err), 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_before_edge", int'(in_ready), 0);
    step();
    checkOutput("in_ready_after_edge", int'(in_ready), 1);

    // Directed table; the first vector also exercises output backpressure on beat index 1.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b);
      drainJob(vecs[v].c, vecs[v].e, (v == 0) ? 1 : -1, LAT);
    end

    // ena low for 5 cycles mid-COMPUTE stretches latency by 5.
    applyStimulus(vecs[0].a, vecs[0].b);
    step();
    ena = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      checkOutput("stall_out_valid", int'(out_valid), 0);
      checkOutput("stall_busy", int'(busy), 1);
    end
    ena = 1'b1;
    drainJob(vecs[0].c, vecs[0].e, -1, LAT + 5);

    // clr mid-COMPUTE aborts the job without any result beat.
    applyStimulus(vecs[3].a, vecs[3].b);
    step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
    checkOutput("clr_in_ready", int'(in_ready), 1);
    checkOutput("clr_busy", int'(busy), 0);
    seen = 0;
    for (int s = 0; s < 15; s++) begin
      if (out_valid) seen++;
      step();
    end
    checkOutput("clr_no_out_valid", seen, 0);
    applyStimulus(vecs[2].a, vecs[2].b);
    drainJob(vecs[2].c, vecs[2].e, -1, LAT);

    // Reset during DRAIN drops out_valid immediately.
    applyStimulus(vecs[0].a, vecs[0].b);
    seen = 0;
    while (!out_valid && seen < 50) begin
      step();
      seen++;
    end
    checkOutput("pre_reset_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_out_last", int'(out_last), 0);
    step();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready_low", int'(in_ready), 0);
    step();
    checkOutput("rst_in_ready_high", int'(in_ready), 1);

    for (int r = 0; r < 8; r++) randomJob(int'($urandom_range(0, 5)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_seq_nxn.md
Name: matmul_seq_nxn

Overview:
Parametrised NxN matrix multiplier that computes C = A x B over W-bit elements.
- Operands arrive as a valid/ready stream, one A element and one B element per beat, row-major.
- One multiply-accumulate (MAC) per cycle; results drain as a valid/ready stream with a last marker.
- Supersedes the fixed 2x2, 2-bit combinational multiplier in tile top-levels; tile wrapper maps pins to these ports.

Parameters:
N, 2, matrix dimension (2..4).
W, 2, element width in bits (1..4).
MAX_VAL, 2, largest legal element magnitude; elements beyond it flag an error.
(derived localparam) ACC_W = 2*W + clog2(N), result width.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low = full stall
clr  input  1  synchronous abort to LOAD, clears all state
in_valid  input  1  operand beat valid
in_ready  output  1  operand beat accepted when in_valid & in_ready
in_a  input  W  element A[r][c] of current beat
in_b  input  W  element B[r][c] of current beat
out_valid  output  1  result beat valid
out_ready  input  1  result consumer ready
out_data  output  ACC_W  element C[r][c], row-major
out_last  output  1  high with C[N-1][N-1]
busy  output  1  high in COMPUTE or DRAIN
err  output  1  sticky range error for current job

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on rst_n: all state cleared immediately.
- Reset values: state=LOAD, in_ready=0 until first edge with ena, out_valid=0, out_data=0, out_last=0, busy=0, err=0.
- A/B storage: N*N entries each; C storage: N*N entries of ACC_W bits.
- FSM LOAD -> COMPUTE -> DRAIN -> LOAD.
- LOAD: in_ready = ena. Each handshake writes in_a/in_b to index cnt and increments cnt.
  - Any element > MAX_VAL sets err.
  - The handshake at cnt = N*N-1 moves to COMPUTE with i=j=k=0 and acc=0.
- COMPUTE: one MAC per cycle on A[i][k]*B[k][j].
  - When k=N-1, write C[i][j] = acc+product, clear acc, advance j, then i.
  - Exactly N^3 cycles, then DRAIN.
  - in_ready=0; busy=1.
- DRAIN: out_valid=1; out_data = C[idx], or 0 for every beat if err=1.
  - idx advances only on out_valid & out_ready. Data and valid stay stable while out_ready=0.
  - out_last=1 at idx=N*N-1. Its handshake returns to LOAD and clears err, idx and cnt.
- Latency: first out_valid is N^3+1 cycles after the cycle of the final operand handshake.
- ena=0: no state, counter or storage changes. in_ready and out_valid are forced 0; out_data holds.
- clr=1 (with ena): returns to LOAD from any state next edge, clears err and counters. No out_valid is produced for the aborted job. clr has priority over any handshake in the same cycle.
- Arithmetic: products and sums are zero-extended to ACC_W; overflow is impossible by construction.
- rst_n asserted mid-job: the job is discarded; the post-reset state equals the reset values above.

Optional Feature:
MATMUL_SIGNED_EN.
- Defined: in_a/in_b are two's complement. Products and sums are sign-extended to ACC_W and out_data is signed. err is set when an element is > MAX_VAL or < -MAX_VAL.
- Undefined: unsigned operation as described above.

Test Plan:
- Basic (N=2, W=2): A=[[1,2],[2,1]], B=[[2,0],[1,2]] -> out beats 4,4,5,2; out_last on 4th; first out_valid 9 cycles after last load; err=0.
- Range error: A=[[3,1],[1,1]], B=I -> four beats of 0, err=1 throughout DRAIN, err=0 after last handshake.
- Max legal: all elements 2 -> four beats of 8.
- Backpressure: in the basic case, hold out_ready=0 for 3 cycles at beat 2 -> out_data=4 and out_valid stay stable; sequence is unchanged.
- Stall/abort: ena=0 for 5 cycles mid-COMPUTE -> latency +5 and results correct. clr during COMPUTE -> in_ready=1 next cycle, no out_valid, next job correct. rst_n low during DRAIN -> out_valid=0 immediately.
- Signed (macro on, N=2, W=3, MAX_VAL=3): A=[[-1,2],[3,0]], B=I -> beats -1,2,3,0 (sign-extended).
